// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Control vector bit order: {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_bubble, fp_busy, halted}.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FP_WAIT    = 2'd1,
    HALT_DRAIN = 2'd2,
    HALTED     = 2'd3
  } state_e;

  localparam int FP_LATENCY_DFLT = 4;
  localparam int HALT_DRAIN_DFLT = 3;
  localparam int STALL_W         = 16;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_bubble;
    logic fp_busy;
    logic halted;
  } hz_ctl_t;

  localparam hz_ctl_t CTL_RUN    = 8'b1110_0000;
  localparam hz_ctl_t CTL_FP     = 8'b0000_0110;
  // Load-use and halt-drain both hold PC/IF-ID and bubble ID/EX.
  localparam hz_ctl_t CTL_HOLD   = 8'b0010_1000;
  localparam hz_ctl_t CTL_HALTED = 8'b0000_0001;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-facing bundle of the hazard controller: ID/EX observations in, stage controls out.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [3:0]         id_readReg1;
  logic [3:0]         id_readReg2;
  logic               id_use1;
  logic               id_use2;
  logic               id_halt;
  logic               ex_memread;
  logic [3:0]         ex_dest;
  logic               ex_fpc;
  logic               ex_branch_taken;
  logic               pc_write;
  logic               ifid_write;
  logic               idex_write;
  logic               ifid_flush;
  logic               idex_flush;
  logic               exmem_bubble;
  logic               fp_busy;
  logic               halted;
  logic [STALL_W-1:0] stall_count;

  modport master (
    output id_readReg1, id_readReg2, id_use1, id_use2, id_halt,
           ex_memread, ex_dest, ex_fpc, ex_branch_taken,
    input  pc_write, ifid_write, idex_write, ifid_flush, idex_flush,
           exmem_bubble, fp_busy, halted, stall_count
  );

  modport slave (
    input  id_readReg1, id_readReg2, id_use1, id_use2, id_halt,
           ex_memread, ex_dest, ex_fpc, ex_branch_taken,
    output pc_write, ifid_write, idex_write, ifid_flush, idex_flush,
           exmem_bubble, fp_busy, halted, stall_count
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter16.sv
// 16-bit saturating event counter with synchronous clear.
module sat_counter16
  import hazard_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [STALL_W-1:0] count
);

  logic [STALL_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc && (count_q != {STALL_W{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: load-use, branch squash, multi-cycle FP occupancy of EX, halt drain.
// Outputs are Mealy on state/cnt/inputs and forced low while reset is asserted.
module hazard_ctrl #(
  parameter int FP_LATENCY = hazard_ctrl_pkg::FP_LATENCY_DFLT,
  parameter int HALT_DRAIN = hazard_ctrl_pkg::HALT_DRAIN_DFLT
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);
  import hazard_ctrl_pkg::*;

  localparam logic [3:0] FP_CNT_INIT   = 4'((FP_LATENCY >= 2) ? FP_LATENCY - 2 : 0);
  localparam logic [3:0] HALT_CNT_INIT = 4'((HALT_DRAIN >= 1) ? HALT_DRAIN - 1 : 0);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  hz_ctl_t            ctl, ctl_o;
  logic               load_use;
  logic               stall_inc;
  logic [STALL_W-1:0] stall_cnt;

  assign load_use = hz.ex_memread &&
                    ((hz.id_use1 && (hz.ex_dest == hz.id_readReg1)) ||
                     (hz.id_use2 && (hz.ex_dest == hz.id_readReg2)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl     = CTL_RUN;
    case (state_q)
      RUN: begin
        if (hz.ex_branch_taken) begin
          ctl.ifid_flush = 1'b1;
          ctl.idex_flush = 1'b1;
        end else if (hz.ex_fpc) begin
          // Single-cycle FP only flags occupancy; nothing else is evaluated.
          ctl.fp_busy = 1'b1;
          if (FP_LATENCY >= 2) begin
            ctl     = CTL_FP;
            state_d = FP_WAIT;
            cnt_d   = FP_CNT_INIT;
          end
        end else if (load_use) begin
          ctl = CTL_HOLD;
        end else if (hz.id_halt) begin
          ctl     = CTL_HOLD;
          state_d = hazard_ctrl_pkg::HALT_DRAIN;
          cnt_d   = HALT_CNT_INIT;
        end
      end
      FP_WAIT: begin
        if (cnt_q != 4'd0) begin
          ctl   = CTL_FP;
          cnt_d = cnt_q - 4'd1;
        end else begin
          ctl.fp_busy = 1'b1;
          state_d     = RUN;
        end
      end
      hazard_ctrl_pkg::HALT_DRAIN: begin
        ctl = CTL_HOLD;
        if (cnt_q == 4'd0) state_d = HALTED;
        else               cnt_d   = cnt_q - 4'd1;
      end
      HALTED:  ctl     = CTL_HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_inc = ((state_q == RUN) || (state_q == FP_WAIT)) && !ctl.pc_write;

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (1'b0),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  assign ctl_o = reset ? ctl : hz_ctl_t'('0);

  assign hz.pc_write     = ctl_o.pc_write;
  assign hz.ifid_write   = ctl_o.ifid_write;
  assign hz.idex_write   = ctl_o.idex_write;
  assign hz.ifid_flush   = ctl_o.ifid_flush;
  assign hz.idex_flush   = ctl_o.idex_flush;
  assign hz.exmem_bubble = ctl_o.exmem_bubble;
  assign hz.fp_busy      = ctl_o.fp_busy;
  assign hz.halted       = ctl_o.halted;
  assign hz.stall_count  = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FP_LATENCY=4, HALT_DRAIN=3).
// Output vector: {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_bubble, fp_busy, halted}.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_asserts = 0;
  int   n_fail    = 0;
  logic [15:0] exp_sc;

  localparam logic [7:0] O_ZERO   = 8'b0000_0000;
  localparam logic [7:0] O_RUN    = 8'b1110_0000;
  localparam logic [7:0] O_LU     = 8'b0010_1000;
  localparam logic [7:0] O_FP     = 8'b0000_0110;
  localparam logic [7:0] O_REL    = 8'b1110_0010;
  localparam logic [7:0] O_BR     = 8'b1111_1000;
  localparam logic [7:0] O_HALTED = 8'b0000_0001;

  hazard_ctrl_if hif();

  hazard_ctrl #(.FP_LATENCY(4), .HALT_DRAIN(3)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    outs = {hif.pc_write, hif.ifid_write, hif.idex_write, hif.ifid_flush,
            hif.idex_flush, hif.exmem_bubble, hif.fp_busy, hif.halted};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    hif.id_readReg1 = 4'd0;  hif.id_readReg2 = 4'd0;
    hif.id_use1 = 1'b0;      hif.id_use2 = 1'b0;
    hif.id_halt = 1'b0;      hif.ex_memread = 1'b0;
    hif.ex_dest = 4'd0;      hif.ex_fpc = 1'b0;
    hif.ex_branch_taken = 1'b0;
  endtask

  task automatic set_lu_r3();
    hif.ex_memread = 1'b1; hif.ex_dest = 4'd3;
    hif.id_readReg1 = 4'd3; hif.id_use1 = 1'b1;
  endtask

  initial begin
    clr_in();
    reset = 1'b0;
    #2;
    chk("reset_outs", 16'(outs()), 16'(O_ZERO));
    chk("reset_sc", hif.stall_count, 16'h0000);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("run_default", 16'(outs()), 16'(O_RUN));
    exp_sc = 16'd0;

    // Load-use through readReg1
    set_lu_r3();
    #1 chk("lu_use1", 16'(outs()), 16'(O_LU));
    tick(); exp_sc++;
    hif.ex_memread = 1'b0;
    #1 chk("lu_next", 16'(outs()), 16'(O_RUN));
    chk("lu_sc", hif.stall_count, exp_sc);

    // Load-use through readReg2
    clr_in();
    hif.ex_memread = 1'b1; hif.ex_dest = 4'd5; hif.id_readReg2 = 4'd5;
    hif.id_use2 = 1'b1; hif.id_readReg1 = 4'd3;
    #1 chk("lu_use2", 16'(outs()), 16'(O_LU));
    tick(); exp_sc++;
    // Register matches but the operand is unused: no hazard
    hif.id_use2 = 1'b0;
    #1 chk("lu_unused", 16'(outs()), 16'(O_RUN));
    tick();
    // Operand used, but EX is not a load
    hif.id_use2 = 1'b1; hif.ex_memread = 1'b0;
    #1 chk("lu_noload", 16'(outs()), 16'(O_RUN));
    tick();
    chk("lu_sc2", hif.stall_count, exp_sc);

    // FP op: 3 stall cycles then release, then back-to-back second op
    clr_in();
    hif.ex_fpc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("fp1_stall", 16'(outs()), 16'(O_FP));
      tick(); exp_sc++;
    end
    chk("fp1_rel", 16'(outs()), 16'(O_REL));
    chk("fp1_sc", hif.stall_count, exp_sc);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1 chk("fp2_stall", 16'(outs()), 16'(O_FP));
      tick(); exp_sc++;
    end
    chk("fp2_rel", 16'(outs()), 16'(O_REL));
    tick();
    hif.ex_fpc = 1'b0;
    #1 chk("fp_after", 16'(outs()), 16'(O_RUN));
    chk("fp_sc", hif.stall_count, exp_sc);

    // Branch beats FP, load-use and halt
    set_lu_r3();
    hif.id_halt = 1'b1; hif.ex_fpc = 1'b1; hif.ex_branch_taken = 1'b1;
    #1 chk("br_prio", 16'(outs()), 16'(O_BR));
    tick();
    clr_in();
    #1 chk("br_next", 16'(outs()), 16'(O_RUN));
    chk("br_sc", hif.stall_count, exp_sc);

    // Reset in second FP_WAIT cycle
    hif.ex_fpc = 1'b1;
    tick(); tick();
    #1 chk("rst_pre", 16'(outs()), 16'(O_FP));
    reset = 1'b0;
    #1 chk("rst_fp_outs", 16'(outs()), 16'(O_ZERO));
    chk("rst_fp_sc", hif.stall_count, 16'h0000);
    hif.ex_fpc = 1'b0;
    #1 reset = 1'b1;
    #1 chk("rst_rel", 16'(outs()), 16'(O_RUN));
    tick();
    chk("rst_run", 16'(outs()), 16'(O_RUN));
    chk("rst_sc", hif.stall_count, 16'h0000);

    // Saturation of stall_count
    set_lu_r3();
    repeat (65534) tick();
    chk("sat_fffe", hif.stall_count, 16'hFFFE);
    tick();
    chk("sat_ffff", hif.stall_count, 16'hFFFF);
    repeat (4465) tick();
    chk("sat_hold", hif.stall_count, 16'hFFFF);
    chk("sat_outs", 16'(outs()), 16'(O_LU));
    clr_in();
    tick();

    // Halt: T, three drain cycles, halted from T+4
    hif.id_halt = 1'b1;
    #1 chk("halt_t", 16'(outs()), 16'(O_LU));
    tick();
    hif.id_halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("halt_drain", 16'({hif.pc_write, hif.ifid_write, hif.idex_flush, hif.halted}), 16'h0002);
      tick();
    end
    chk("halted", 16'(outs()), 16'(O_HALTED));
    set_lu_r3();
    hif.ex_fpc = 1'b1; hif.ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("halted_hold", 16'(outs()), 16'(O_HALTED));
      tick();
    end
    chk("halted_sc", hif.stall_count, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
